line_buffer_scheduler: RTL and testbench
========================================

Name: line_buffer_scheduler

Overview:
- Sequences the ping-pong line-buffer capture path between the pixel stream and the processor.
- Accepts 32-bit pixel words from the capture datapath and writes each line to buffer 0 or buffer 1 through an Avalon-MM write master, alternating between the two.
- Sets a per-buffer full flag when a line is complete. The processor clears each flag after it has read that buffer.
- Stalls the stream while the target buffer is still full, and reports standby, frame completion, overrun and sync errors.

Parameters:
- BYTES_PER_WORD, 4, address increment per pixel word; must be a power of 2.
- LINE_W, 16, width of the width, height and line counters.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start_capture  in  1  level. Rising edge starts one frame; low while busy aborts the frame.
- capture_width  in  LINE_W  pixel words per line; latched at start.
- capture_height  in  LINE_W  lines per frame; latched at start.
- buff0_base  in  32  byte base address of buffer 0; latched at start.
- buff1_base  in  32  byte base address of buffer 1; latched at start.
- buff0_clear  in  1  one-cycle pulse from the processor; clears buff0full.
- buff1_clear  in  1  one-cycle pulse from the processor; clears buff1full.
- in_valid  in  1  pixel word valid.
- in_sof  in  1  qualifies the first word of a frame.
- in_data  in  32  pixel word.
- in_ready  out  1  a beat is accepted when in_valid && in_ready.
- mem_write  out  1  Avalon write request.
- mem_address  out  32  byte address.
- mem_writedata  out  32  write data.
- mem_waitrequest  in  1  Avalon stall.
- buff0full  out  1  level; buffer 0 holds a complete line.
- buff1full  out  1  level; buffer 1 holds a complete line.
- standby  out  1  high in IDLE.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- line_count  out  LINE_W  number of lines completed in the current frame.
- overrun  out  1  sticky. Set when in_valid is high in WAIT_BUF; cleared at start.
- sync_err  out  1  sticky. Set when in_sof arrives on a non-first word after sync; cleared at start.

Behaviour:

Reset:
- All outputs are 0 except standby=1.
- State is IDLE, sel=0, all counters 0, synced=0.

start_capture edge detection:
- start_capture is registered once; a rising edge is start_q=0 && start_capture=1.

IDLE:
- On a rising edge with width≠0 and height≠0: latch width, height and both bases; clear line_count, overrun, sync_err and synced; set sel=0; go to WAIT_BUF.
- If width or height is 0, the edge is ignored.

WAIT_BUF:
- in_ready=0.
- If buff[sel]full=0, go to FILL with word_cnt=0.
- Otherwise stall; overrun is set on any cycle with in_valid=1.

FILL:
- in_ready = !mem_write || !mem_waitrequest.
- Before sync (synced=0): accepted beats with in_sof=0 are dropped. An accepted beat with in_sof=1 sets synced=1 and is written as word 0.
- After sync: each accepted beat is written.
- An accepted in_sof on a beat other than the frame's word 0 sets sync_err; that beat is written as normal data.

Write and line completion:
- A written beat registers mem_write=1, mem_address=base[sel]+word_cnt*BYTES_PER_WORD (mod 2^32) and mem_writedata=in_data, then word_cnt increments.
- mem_write, mem_address and mem_writedata are held while mem_waitrequest=1. mem_write drops after completion unless a new beat is accepted in the same cycle.
- When the beat for word width-1 is accepted, in_ready goes low. On that write's completion cycle (mem_write && !mem_waitrequest):
  - set buff[sel]full;
  - toggle sel;
  - increment line_count;
  - if line_count+1 == height, go to DONE; otherwise go to WAIT_BUF.
- Latency: the first pixel accepted reaches the mem_write output one cycle later. Throughput is 1 word/cycle with no waitrequest.

DONE:
- Pulse frame_done for one cycle, then go to IDLE.
- A new frame requires a new rising edge of start_capture.

Full flags:
- The set condition is line completion; the clear condition is buffN_clear.
- If set and clear occur on the same buffer in the same cycle, set wins.
- Clears while IDLE are honoured.

Abort (start_capture=0 in WAIT_BUF or FILL):
- in_ready drops immediately.
- Any held mem_write completes first (Avalon rule), then go to IDLE.
- No frame_done; full flags and line_count are preserved.

Other:
- Asynchronous reset mid-write drops mem_write immediately.
- Inputs other than start_capture are sampled only at start; later changes are ignored until the next frame.

Test Plan:
- Nominal frame: width=4, height=2, bases 0x1000/0x2000, no waitrequest, processor clears each flag promptly. Writes go to 0x1000,0x1004,0x1008,0x100C then 0x2000..0x200C. buff0full rises after the 4th write. frame_done pulses once; line_count=2; standby returns to 1.
- Pre-sync discard: three beats with in_sof=0, then an in_sof beat carrying 0xAA. The first three beats are dropped; the first write is 0xAA at 0x1000.
- Buffer full stall: height=3 with buff0full never cleared. After line 1 (buffer 1) the block waits in WAIT_BUF with in_ready=0. in_valid=1 there sets overrun. buff0_clear resumes writes at buff0_base.
- Waitrequest: waitrequest held for 3 cycles on word 1. Address and data stay stable for those 3 cycles, in_ready stays 0, and no beat is lost.
- Simultaneous set/clear: buff0_clear in the same cycle as line-0 completion → buff0full=1.
- Abort and reset:
  - start_capture dropped mid-line with waitrequest high → the pending write completes, then IDLE with no frame_done.
  - reset_n low mid-FILL → all outputs at reset values asynchronously.
  - width=0 with a start edge → stays IDLE.

Source files
------------

// File: rtl/line_buffer_scheduler.sv
// Ping-pong line-buffer capture sequencer: writes each incoming line to buffer 0/1
// through an Avalon-MM write master and hands completed buffers to the processor.
module line_buffer_scheduler #(
    parameter int BYTES_PER_WORD = 4,
    parameter int LINE_W         = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_capture,
    input  logic [LINE_W-1:0] capture_width,
    input  logic [LINE_W-1:0] capture_height,
    input  logic [31:0]       buff0_base,
    input  logic [31:0]       buff1_base,
    input  logic              buff0_clear,
    input  logic              buff1_clear,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_writedata,
    input  logic              mem_waitrequest,
    output logic              buff0full,
    output logic              buff1full,
    output logic              standby,
    output logic              frame_done,
    output logic [LINE_W-1:0] line_count,
    output logic              overrun,
    output logic              sync_err
);

    // state    | meaning
    // IDLE     | standby, waiting for a start_capture rising edge
    // WAIT_BUF | waiting for the target buffer to be released by the processor
    // FILL     | accepting pixel words and writing the current line
    // DONE     | one-cycle frame_done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, WAIT_BUF, FILL, DONE} state_t;

    localparam int SHIFT = $clog2(BYTES_PER_WORD);

    state_t            state;
    state_t            state_nxt;
    logic              start_q;
    logic              sel;
    logic              synced;
    logic              last_pending;
    logic [LINE_W-1:0] width_r;
    logic [LINE_W-1:0] height_r;
    logic [LINE_W-1:0] word_cnt;
    logic [31:0]       base0_r;
    logic [31:0]       base1_r;

    logic              start_ok;
    logic              mem_done;
    logic              cur_full;
    logic              line_end;
    logic              frame_end;
    logic              accept;
    logic              write_beat;
    logic [31:0]       wr_addr;

    assign mem_done   = mem_write && !mem_waitrequest;
    assign cur_full   = sel ? buff1full : buff0full;
    assign start_ok   = start_capture && !start_q &&
                        (capture_width != '0) && (capture_height != '0);
    // An abort that lets the last write drain does not count as a completed line.
    assign line_end   = (state == FILL) && start_capture && mem_done && last_pending;
    assign frame_end  = line_end && ((line_count + LINE_W'(1)) == height_r);
    assign accept     = in_valid && in_ready;
    assign write_beat = accept && (synced || in_sof);
    assign wr_addr    = (sel ? base1_r : base0_r) + (32'(word_cnt) << SHIFT);
    assign standby    = (state == IDLE);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = WAIT_BUF;
            end
            WAIT_BUF: begin
                if (!start_capture) state_nxt = IDLE;
                else if (!cur_full) state_nxt = FILL;
            end
            FILL: begin
                if (!start_capture) begin
                    if (!mem_write || !mem_waitrequest) state_nxt = IDLE;
                end else begin
                    in_ready = !last_pending && (!mem_write || !mem_waitrequest);
                    if (line_end) state_nxt = frame_end ? DONE : WAIT_BUF;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q       <= 1'b0;
            sel           <= 1'b0;
            synced        <= 1'b0;
            last_pending  <= 1'b0;
            width_r       <= '0;
            height_r      <= '0;
            word_cnt      <= '0;
            base0_r       <= '0;
            base1_r       <= '0;
            line_count    <= '0;
            overrun       <= 1'b0;
            sync_err      <= 1'b0;
            frame_done    <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
        end else begin
            start_q    <= start_capture;
            frame_done <= frame_end;

            if ((state == IDLE) && start_ok) begin
                width_r      <= capture_width;
                height_r     <= capture_height;
                base0_r      <= buff0_base;
                base1_r      <= buff1_base;
                line_count   <= '0;
                overrun      <= 1'b0;
                sync_err     <= 1'b0;
                synced       <= 1'b0;
                sel          <= 1'b0;
                last_pending <= 1'b0;
                word_cnt     <= '0;
            end

            if (state == WAIT_BUF) begin
                word_cnt     <= '0;
                last_pending <= 1'b0;
                if (cur_full && in_valid) overrun <= 1'b1;
            end

            if (write_beat) begin
                mem_write     <= 1'b1;
                mem_address   <= wr_addr;
                mem_writedata <= in_data;
                word_cnt      <= word_cnt + LINE_W'(1);
                if (word_cnt == (width_r - LINE_W'(1))) last_pending <= 1'b1;
            end else if (mem_done) begin
                mem_write <= 1'b0;
            end

            if (accept && in_sof) begin
                if (synced) sync_err <= 1'b1;
                else        synced   <= 1'b1;
            end

            if (line_end) begin
                sel          <= ~sel;
                line_count   <= line_count + LINE_W'(1);
                last_pending <= 1'b0;
            end
        end
    end

    // A completing line beats a same-cycle processor clear on that buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buff0full <= 1'b0;
            buff1full <= 1'b0;
        end else begin
            if (line_end && !sel)  buff0full <= 1'b1;
            else if (buff0_clear)  buff0full <= 1'b0;
            if (line_end && sel)   buff1full <= 1'b1;
            else if (buff1_clear)  buff1full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Self-checking bench for line_buffer_scheduler: table-driven and random frames scored
// against an address/data list model, plus hand sequences for stall/abort/reset corners.
module tb_line_buffer_scheduler;
    localparam int BPW = 4;
    localparam int LW  = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start_capture;
    logic [LW-1:0] capture_width;
    logic [LW-1:0] capture_height;
    logic [31:0]   buff0_base;
    logic [31:0]   buff1_base;
    logic          buff0_clear;
    logic          buff1_clear;
    logic          in_valid;
    logic          in_sof;
    logic [31:0]   in_data;
    logic          in_ready;
    logic          mem_write;
    logic [31:0]   mem_address;
    logic [31:0]   mem_writedata;
    logic          mem_waitrequest;
    logic          buff0full;
    logic          buff1full;
    logic          standby;
    logic          frame_done;
    logic [LW-1:0] line_count;
    logic          overrun;
    logic          sync_err;

    always #5 clk = ~clk;

    line_buffer_scheduler #(.BYTES_PER_WORD(BPW), .LINE_W(LW)) dut (
        .clk(clk), .reset_n(reset_n), .start_capture(start_capture),
        .capture_width(capture_width), .capture_height(capture_height),
        .buff0_base(buff0_base), .buff1_base(buff1_base),
        .buff0_clear(buff0_clear), .buff1_clear(buff1_clear),
        .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data), .in_ready(in_ready),
        .mem_write(mem_write), .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_waitrequest(mem_waitrequest), .buff0full(buff0full), .buff1full(buff1full),
        .standby(standby), .frame_done(frame_done), .line_count(line_count),
        .overrun(overrun), .sync_err(sync_err)
    );

    typedef struct {
        int          w;
        int          h;
        logic [31:0] b0;
        logic [31:0] b1;
        int          junk;
        int          err_idx;
        int          wr_pct;
        int          clr_pct;
        int          exp_lines;
        logic        exp_serr;
    } frame_t;

    int          checks   = 0;
    int          failures = 0;
    int          fd_count = 0;
    logic        acc       = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    frame_t      tbl[7];
    logic [31:0] stall_addr[6] = '{32'h100, 32'h104, 32'h200, 32'h204, 32'h100, 32'h104};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // One clock: sample the bus just before the edge, then step to 1ns after the edge.
    task automatic cyc();
        #1;
        acc = in_valid && in_ready;
        if (prev_hold) begin
            chk("hold_write", mem_write, 1'b1);
            chk("hold_addr", mem_address, prev_addr);
            chk("hold_data", mem_writedata, prev_data);
        end
        if (mem_write && mem_waitrequest) chk("ready_in_stall", in_ready, 1'b0);
        prev_hold = mem_write && mem_waitrequest;
        prev_addr = mem_address;
        prev_data = mem_writedata;
        if (mem_write && !mem_waitrequest) begin
            wq_addr.push_back(mem_address);
            wq_data.push_back(mem_writedata);
        end
        if (frame_done) fd_count++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        buff0_clear = 1'b1;
        buff1_clear = 1'b1;
        cyc();
        buff0_clear = 1'b0;
        buff1_clear = 1'b0;
    endtask

    task automatic start_frame(input int w, input int h, input logic [31:0] b0, input logic [31:0] b1);
        capture_width  = LW'(w);
        capture_height = LW'(h);
        buff0_base     = b0;
        buff1_base     = b1;
        start_capture  = 1'b0;
        cyc();
        start_capture  = 1'b1;
        cyc();
    endtask

    task automatic offer(input logic [31:0] d, input logic sof, input string tag);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        acc      = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) cyc();
        in_valid = 1'b0;
        chk(tag, acc, 1'b1);
    endtask

    task automatic wait_done(input int fd0, input string tag);
        for (int n = 0; n < 40 && fd_count == fd0; n++) cyc();
        chk(tag, fd_count - fd0, 1);
    endtask

    // Model: the frame is the list of post-sync words; word k lands in buffer (k/w)%2
    // at byte offset (k%w)*BPW, wrapping mod 2^32.
    task automatic run_frame(input frame_t f, input string tag);
        logic [31:0] sd[$];
        logic        ss[$];
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        logic [31:0] d;
        int          fd0;
        for (int j = 0; j < f.junk; j++) begin
            sd.push_back($urandom);
            ss.push_back(1'b0);
        end
        for (int k = 0; k < f.w * f.h; k++) begin
            d = $urandom;
            sd.push_back(d);
            ss.push_back((k == 0) || (k == f.err_idx));
            ea.push_back((((k / f.w) % 2) == 1 ? f.b1 : f.b0) + 32'((k % f.w) * BPW));
            ed.push_back(d);
        end
        wq_addr.delete();
        wq_data.delete();
        clear_flags();
        fd0 = fd_count;
        start_frame(f.w, f.h, f.b0, f.b1);
        capture_width  = LW'($urandom);
        capture_height = LW'($urandom);
        buff0_base     = $urandom;
        buff1_base     = $urandom;
        for (int n = 0; n < 1500 && fd_count == fd0; n++) begin
            mem_waitrequest = ($urandom_range(99) < f.wr_pct);
            in_valid = (sd.size() > 0) && ($urandom_range(3) != 0);
            if (sd.size() > 0) begin
                in_data = sd[0];
                in_sof  = ss[0];
            end
            buff0_clear = buff0full && ($urandom_range(99) < f.clr_pct);
            buff1_clear = buff1full && ($urandom_range(99) < f.clr_pct);
            cyc();
            if (acc) begin
                void'(sd.pop_front());
                void'(ss.pop_front());
            end
        end
        in_valid        = 1'b0;
        buff0_clear     = 1'b0;
        buff1_clear     = 1'b0;
        mem_waitrequest = 1'b0;
        chk($sformatf("%s_frame_done", tag), fd_count - fd0, 1);
        chk($sformatf("%s_standby", tag), standby, 1'b1);
        chk($sformatf("%s_line_count", tag), line_count, f.exp_lines);
        chk($sformatf("%s_sync_err", tag), sync_err, f.exp_serr);
        chk($sformatf("%s_write_count", tag), wq_addr.size(), ea.size());
        for (int k = 0; k < ea.size() && k < wq_addr.size(); k++) begin
            chk($sformatf("%s_addr%0d", tag, k), wq_addr[k], ea[k]);
            chk($sformatf("%s_data%0d", tag, k), wq_data[k], ed[k]);
        end
        start_capture = 1'b0;
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int fd0;
        frame_t rf;
        tbl[0] = '{4, 2, 32'h1000, 32'h2000, 0, 0, 0, 100, 2, 1'b0};
        tbl[1] = '{4, 2, 32'h1000, 32'h2000, 3, 0, 0, 100, 2, 1'b0};
        tbl[2] = '{3, 4, 32'h8000, 32'h9000, 1, 0, 30, 40, 4, 1'b0};
        tbl[3] = '{4, 2, 32'hFFFF_FFF8, 32'h10, 0, 0, 20, 50, 2, 1'b0};
        tbl[4] = '{4, 2, 32'h100, 32'h200, 0, 5, 0, 100, 2, 1'b1};
        tbl[5] = '{2, 3, 32'h0, 32'h40, 2, 2, 10, 60, 3, 1'b1};
        tbl[6] = '{1, 5, 32'hA000, 32'hB000, 0, 0, 25, 70, 5, 1'b0};

        reset_n = 1'b0; start_capture = 1'b0; capture_width = '0; capture_height = '0;
        buff0_base = '0; buff1_base = '0; buff0_clear = 1'b0; buff1_clear = 1'b0;
        in_valid = 1'b0; in_sof = 1'b0; in_data = '0; mem_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_standby", standby, 1'b1);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_full0", buff0full, 1'b0);
        chk("rst_full1", buff1full, 1'b0);
        chk("rst_line_count", line_count, 0);
        chk("rst_flags", {frame_done, overrun, sync_err}, 3'b000);
        chk("rst_address", mem_address, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero width or height: the start edge is ignored.
        wq_addr.delete();
        start_frame(0, 3, 32'h1000, 32'h2000);
        in_valid = 1'b1; in_sof = 1'b1; in_data = 32'h55;
        repeat (4) cyc();
        chk("w0_standby", standby, 1'b1);
        chk("w0_accept", acc, 1'b0);
        start_frame(3, 0, 32'h1000, 32'h2000);
        repeat (4) cyc();
        chk("h0_standby", standby, 1'b1);
        chk("w0h0_writes", wq_addr.size(), 0);
        in_valid = 1'b0; in_sof = 1'b0; start_capture = 1'b0;
        cyc();

        foreach (tbl[i]) run_frame(tbl[i], $sformatf("tbl%0d", i));

        // Buffer-full stall: buffer 0 is never released until the third line.
        wq_addr.delete(); wq_data.delete();
        clear_flags();
        fd0 = fd_count;
        start_frame(2, 3, 32'h100, 32'h200);
        offer(32'd11, 1'b1, "stall_acc11");
        offer(32'd12, 1'b0, "stall_acc12");
        offer(32'd13, 1'b0, "stall_acc13");
        offer(32'd14, 1'b0, "stall_acc14");
        repeat (3) cyc();
        chk("stall_full0", buff0full, 1'b1);
        chk("stall_full1", buff1full, 1'b1);
        chk("stall_lines", line_count, 2);
        chk("stall_overrun_pre", overrun, 1'b0);
        in_valid = 1'b1; in_data = 32'd15; in_sof = 1'b0;
        repeat (3) begin
            cyc();
            chk("stall_accept", acc, 1'b0);
        end
        chk("stall_overrun", overrun, 1'b1);
        in_valid = 1'b0;
        buff0_clear = 1'b1;
        cyc();
        buff0_clear = 1'b0;
        chk("stall_cleared", buff0full, 1'b0);
        offer(32'd15, 1'b0, "stall_acc15");
        offer(32'd16, 1'b0, "stall_acc16");
        wait_done(fd0, "stall_done");
        chk("stall_lines_end", line_count, 3);
        chk("stall_writes", wq_addr.size(), 6);
        for (int k = 0; k < 6 && k < wq_addr.size(); k++) begin
            chk($sformatf("stall_addr%0d", k), wq_addr[k], stall_addr[k]);
            chk($sformatf("stall_data%0d", k), wq_data[k], 32'(11 + k));
        end
        start_capture = 1'b0;

        // Waitrequest held three cycles on word 1.
        wq_addr.delete(); wq_data.delete();
        clear_flags();
        fd0 = fd_count;
        start_frame(4, 1, 32'h3000, 32'h5000);
        offer(32'hA0, 1'b1, "wr_acc0");
        in_valid = 1'b1; in_data = 32'hA1; in_sof = 1'b0;
        cyc();
        chk("wr_acc1", acc, 1'b1);
        mem_waitrequest = 1'b1; in_data = 32'hA2;
        repeat (3) begin
            cyc();
            chk("wr_stall_accept", acc, 1'b0);
            chk("wr_stall_addr", mem_address, 32'h3004);
            chk("wr_stall_data", mem_writedata, 32'hA1);
        end
        mem_waitrequest = 1'b0;
        offer(32'hA2, 1'b0, "wr_acc2");
        offer(32'hA3, 1'b0, "wr_acc3");
        wait_done(fd0, "wr_done");
        chk("wr_writes", wq_addr.size(), 4);
        for (int k = 0; k < 4 && k < wq_addr.size(); k++) begin
            chk($sformatf("wr_addr%0d", k), wq_addr[k], 32'h3000 + 32'(4 * k));
            chk($sformatf("wr_data%0d", k), wq_data[k], 32'hA0 + 32'(k));
        end
        start_capture = 1'b0;

        // Line completion and buff0_clear in the same cycle: set wins; IDLE clears honoured.
        clear_flags();
        fd0 = fd_count;
        start_frame(1, 1, 32'h6000, 32'h7000);
        offer(32'h5A, 1'b1, "sc_acc");
        buff0_clear = 1'b1;
        cyc();
        buff0_clear = 1'b0;
        chk("sc_full0", buff0full, 1'b1);
        wait_done(fd0, "sc_done");
        buff0_clear = 1'b1;
        cyc();
        buff0_clear = 1'b0;
        chk("idle_clear", buff0full, 1'b0);
        start_capture = 1'b0;
        cyc();

        // Abort with a write stalled: the write drains, then IDLE without frame_done.
        wq_addr.delete(); wq_data.delete();
        clear_flags();
        fd0 = fd_count;
        start_frame(4, 1, 32'h4000, 32'h5000);
        offer(32'hB0, 1'b1, "ab_acc0");
        offer(32'hB1, 1'b0, "ab_acc1");
        mem_waitrequest = 1'b1; start_capture = 1'b0;
        in_valid = 1'b1; in_data = 32'hB2;
        #1;
        chk("ab_ready_drop", in_ready, 1'b0);
        cyc();
        chk("ab_held1", mem_write, 1'b1);
        cyc();
        chk("ab_held2", mem_write, 1'b1);
        chk("ab_addr", mem_address, 32'h4004);
        mem_waitrequest = 1'b0;
        cyc();
        chk("ab_write_drop", mem_write, 1'b0);
        chk("ab_standby", standby, 1'b1);
        in_valid = 1'b0;
        repeat (3) cyc();
        chk("ab_no_done", fd_count - fd0, 0);
        chk("ab_lines", line_count, 0);
        chk("ab_writes", wq_addr.size(), 2);
        if (wq_addr.size() == 2) chk("ab_last_data", wq_data[1], 32'hB1);

        // Asynchronous reset while a write is held.
        clear_flags();
        start_frame(4, 2, 32'h1000, 32'h2000);
        offer(32'hC0, 1'b1, "rs_acc0");
        offer(32'hC1, 1'b0, "rs_acc1");
        mem_waitrequest = 1'b1;
        cyc();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rs_mem_write", mem_write, 1'b0);
        chk("rs_standby", standby, 1'b1);
        chk("rs_in_ready", in_ready, 1'b0);
        chk("rs_address", mem_address, 0);
        chk("rs_line_count", line_count, 0);
        chk("rs_flags", {buff0full, buff1full, frame_done, overrun, sync_err}, 5'b0);
        mem_waitrequest = 1'b0; start_capture = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        prev_hold = 1'b0;

        for (int r = 0; r < 6; r++) begin
            rf.w = $urandom_range(6, 1);
            rf.h = $urandom_range(4, 1);
            rf.b0 = $urandom & 32'hFFFF_FFFC;
            rf.b1 = $urandom & 32'hFFFF_FFFC;
            rf.junk = $urandom_range(3, 0);
            rf.err_idx = 0;
            rf.wr_pct = 25;
            rf.clr_pct = 50;
            rf.exp_lines = rf.h;
            rf.exp_serr = 1'b0;
            run_frame(rf, $sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
